write_back_buffer: RTL
======================

# write_back_buffer

Write-back buffer downstream of the fully associative cache. Captures dirty lines on eviction (`dirty_evict`/`evict_addr` plus victim data), queues them in a small FIFO, and drains them to main memory over a request/acknowledge port. Same-address evictions are coalesced. A combinational lookup port lets the cache's miss path read data that is still buffered, so a refill never returns stale memory contents.

## Interface
- `DEPTH`, 4: number of buffered entries; power of two, ≥2.
- `ADDR_WIDTH`, 8: address width; matches the cache.
- `DATA_WIDTH`, 32: line data width; matches the cache.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `evict_valid`  in  1  dirty victim present; driven from the cache's `dirty_evict`.
- `evict_addr`  in  ADDR_WIDTH  victim address.
- `evict_data`  in  DATA_WIDTH  victim data.
- `evict_ready`  out  1  registered; the buffer can accept a push this cycle.
- `lookup_addr`  in  ADDR_WIDTH  miss-path probe address.
- `lookup_hit`  out  1  combinational; a buffered entry matches `lookup_addr`.
- `lookup_data`  out  DATA_WIDTH  combinational; data of the youngest matching entry, 0 when there is no hit.
- `mem_wr_req`  out  1  registered; write request to memory.
- `mem_wr_addr`  out  ADDR_WIDTH  registered; held stable while `mem_wr_req` is high.
- `mem_wr_data`  out  DATA_WIDTH  registered; held stable while `mem_wr_req` is high.
- `mem_wr_ack`  in  1  memory accepted the write; sampled only while `mem_wr_req` is high.
- `count`  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
**Storage**
- Circular FIFO of `{valid, addr, data}` entries.
- Head and tail pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.

**Push**
- A push is accepted on a rising edge where `evict_valid && evict_ready`.
- If `evict_valid` is high while `evict_ready` is low, the input is ignored. The cache must hold its victim until ready.
- Coalesce: if `evict_addr` matches a valid entry that is not the in-flight head (head while in state `REQ`), overwrite that entry's data. `count` is unchanged.
- Otherwise, write the entry at tail, advance tail, and increment `count`.
- A match against the in-flight head always allocates a new entry.

**evict_ready**
- Next-state value is `count_next < DEPTH`.
- Reset value is 0; it rises on the first edge after `rst_n` deasserts.

**Drain FSM (`IDLE`, `REQ`)**
- `IDLE` → `REQ` when `count != 0`. At the same time, load `mem_wr_addr`/`mem_wr_data` from head and set `mem_wr_req`.
- `REQ` holds until `mem_wr_ack` is high at an edge. At that edge: clear `mem_wr_req`, invalidate head, advance head, decrement `count`, and return to `IDLE`.
- There is one bubble cycle between consecutive requests.

**Simultaneous push and pop**
- A non-coalescing push plus a pop leaves `count` unchanged.
- A coalescing push plus a pop decrements `count`.
- When full, `evict_ready` is 0, so no push can coincide with the pop. Ready returns on the following cycle.

**Lookup**
- Compare `lookup_addr` against all valid entries, including the in-flight head.
- Youngest match (closest to tail) wins.
- Lookup sees pre-edge contents: a same-cycle push is not visible. In the ack cycle the head entry is still visible.

**Reset mid-operation**
- All entries are dropped with no write-back.
- `mem_wr_req` falls immediately (asynchronous).

**Reset values**
- `evict_ready`, `lookup_hit`, `lookup_data`, `mem_wr_req`, `mem_wr_addr`, `mem_wr_data`, `count` are all 0.
- FSM is in `IDLE`; pointers are 0.

## Timing
- Push at edge N: `count` updates at N; `mem_wr_req` rises at N+1 if the FSM was `IDLE`.
- Ack at edge M: `mem_wr_req` is low after M; the next request can rise at M+1.
- Minimum drain rate: one entry per 2 cycles (ack returned in the first cycle of `REQ`).
- Lookup is zero-latency combinational.
- Push-to-`evict_ready` deassert is 1 cycle; `evict_ready` reflects `count` after the edge.

## Structure
- Shared package `wbb_pkg`:
  - `wbb_state_e` {`IDLE`, `REQ`}
  - `wbb_entry_t` struct {`valid`, `addr`, `data`}, parameterised via package localparams matching the cache defaults
- One sub-module, `wbb_match`: combinational match vector plus youngest-priority select (rotated by tail). It serves both the coalesce check and the lookup port.
- Remaining logic (pointers, count, FSM) stays in `write_back_buffer`.

## Test plan
- Push `0x30`/`0x000000C0` with `mem_wr_ack` held 0 → `count`=1, `mem_wr_req`=1 next cycle with addr `0x30`, data `0xC0`. Assert ack for one cycle → `count`=0, `mem_wr_req`=0.
- Ack held 0; push `0x30`, `0x31`, `0x32`, `0x33` → `count`=4, `evict_ready`=0. Extra push of `0x34` is ignored. Ack once → `evict_ready`=1 next cycle. Drain order is `0x30`..`0x33`.
- Ack held 0; push `0x40`/`0x11111111`, then `0x50`/`0x2`, then `0x50`/`0x22222222` → `count`=2 (coalesced). Lookup `0x50` → hit, `0x22222222`. Lookup `0x60` → miss, data 0.
- Ack held 0; push `0x40`/`0x1` (becomes in-flight head), then `0x40`/`0x2` → `count`=2. Lookup `0x40` returns `0x2`. The memory sees `0x1` then `0x2`.
- `rst_n` pulsed low with `mem_wr_req` high and `count`=3 → all outputs 0 immediately. After release: `evict_ready`=1 one cycle later, and no memory write is issued.
- Ack returned 3 cycles after each request; continuous valid pushes of 8 addresses → every address is written exactly once, in order, and `count` never exceeds 4.

Source files
------------

// File: rtl/wbb_pkg.sv
// Shared types for the write-back buffer: drain FSM states and the FIFO
// entry layout. Entry field widths track the cache defaults.
package wbb_pkg;

  localparam int WBB_DEPTH  = 4;
  localparam int WBB_ADDR_W = 8;
  localparam int WBB_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wbb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [WBB_ADDR_W-1:0] addr;
    logic [WBB_DATA_W-1:0] data;
  } wbb_entry_t;

endpackage

// File: rtl/wbb_match.sv
// Address match across all FIFO slots with youngest-first priority.
// Slots are scanned oldest to youngest relative to tail so the last hit
// (the slot closest to tail) wins. Used for both coalescing and lookup.
module wbb_match #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int PTR_WIDTH  = 2
) (
  input  logic [DEPTH-1:0]                 valid,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addrs,
  input  logic [DEPTH-1:0]                 eligible,
  input  logic [PTR_WIDTH-1:0]             tail,
  input  logic [ADDR_WIDTH-1:0]            probe,
  output logic                             hit,
  output logic [PTR_WIDTH-1:0]             idx
);

  logic [DEPTH-1:0]     match;
  logic [PTR_WIDTH-1:0] cand;

  // Raw per-slot match vector.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && eligible[i] && (addrs[i] == probe);
    end
  end

  // Walk from the oldest slot (tail - DEPTH == tail) to the youngest
  // (tail - 1); later hits override earlier ones.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      cand = tail - PTR_WIDTH'(k);
      if (match[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/write_back_buffer.sv
// Write-back buffer: queues dirty victims from the cache, coalesces
// repeated evictions of the same line, drains entries to memory one at a
// time and lets the miss path read lines that are still buffered.
//
// Handshakes:
//   evict: a push happens on a rising edge where evict_valid && evict_ready;
//          evict_ready is registered, and the source holds addr/data while
//          valid is high and ready is low.
//   mem:   mem_wr_req/addr/data are registered and held stable until an
//          edge where mem_wr_ack is high; ack is ignored while req is low.
module write_back_buffer
  import wbb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         evict_valid,
  input  logic [ADDR_WIDTH-1:0]        evict_addr,
  input  logic [DATA_WIDTH-1:0]        evict_data,
  output logic                         evict_ready,
  input  logic [ADDR_WIDTH-1:0]        lookup_addr,
  output logic                         lookup_hit,
  output logic [DATA_WIDTH-1:0]        lookup_data,
  output logic                         mem_wr_req,
  output logic [ADDR_WIDTH-1:0]        mem_wr_addr,
  output logic [DATA_WIDTH-1:0]        mem_wr_data,
  input  logic                         mem_wr_ack,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wbb_state_e state;
  wbb_state_e state_next;

  wbb_entry_t entries [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_next;

  logic [DEPTH-1:0]                 ent_valid;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr;
  logic [DEPTH-1:0]                 co_eligible;

  logic          push;
  logic          coalesce;
  logic          alloc;
  logic          launch;
  logic          pop;
  logic          co_hit;
  logic [PW-1:0] co_idx;
  logic          lk_hit;
  logic [PW-1:0] lk_idx;

  // Flatten entry fields for the matchers; the in-flight head is never a
  // coalesce target because its data is already on the memory port.
  always_comb begin
    ent_valid   = '0;
    ent_addr    = '0;
    co_eligible = '1;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i]   = entries[i].valid;
      ent_addr[i]    = entries[i].addr;
      co_eligible[i] = !((state == REQ) && (head == PW'(i)));
    end
  end

  wbb_match #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PTR_WIDTH  (PW)
  ) u_coalesce_match (
    .valid    (ent_valid),
    .addrs    (ent_addr),
    .eligible (co_eligible),
    .tail     (tail),
    .probe    (evict_addr),
    .hit      (co_hit),
    .idx      (co_idx)
  );

  wbb_match #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PTR_WIDTH  (PW)
  ) u_lookup_match (
    .valid    (ent_valid),
    .addrs    (ent_addr),
    .eligible ({DEPTH{1'b1}}),
    .tail     (tail),
    .probe    (lookup_addr),
    .hit      (lk_hit),
    .idx      (lk_idx)
  );

  // Lookup reflects pre-edge contents, including the in-flight head.
  always_comb begin
    lookup_hit  = lk_hit;
    lookup_data = lk_hit ? entries[lk_idx].data : '0;
  end

  // Push classification and the occupancy that results from this edge.
  always_comb begin
    push       = evict_valid && evict_ready;
    coalesce   = push && co_hit;
    alloc      = push && !co_hit;
    count_next = count + CW'(alloc) - CW'(pop);
  end

  // Drain FSM next-state: launch the head when idle, retire it on ack.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_next = REQ;
          launch     = 1'b1;
        end
      end
      REQ: begin
        if (mem_wr_ack) begin
          state_next = IDLE;
          pop        = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      evict_ready <= 1'b0;
    end else begin
      head        <= head + PW'(pop);
      tail        <= tail + PW'(alloc);
      count       <= count_next;
      evict_ready <= (count_next < CW'(DEPTH));
    end
  end

  // Memory write port. When a coalescing push hits the head on the same
  // edge it is launched, the new victim data is forwarded so the write
  // carries the latest value of the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_req  <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else if (launch) begin
      mem_wr_req  <= 1'b1;
      mem_wr_addr <= entries[head].addr;
      mem_wr_data <= (coalesce && (co_idx == head)) ? evict_data
                                                    : entries[head].data;
    end else if (pop) begin
      mem_wr_req  <= 1'b0;
    end
  end

  // Entry storage: retire head on ack, merge or append victims on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (pop) begin
        entries[head].valid <= 1'b0;
      end
      if (coalesce) begin
        entries[co_idx].data <= evict_data;
      end
      if (alloc) begin
        entries[tail] <= '{valid: 1'b1, addr: evict_addr, data: evict_data};
      end
    end
  end

endmodule
